// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode stage: field positions, widths,
// the two-word opcode prefix and the decode FSM state encoding.
package isa_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 32;

  localparam int OP_MSB   = 15;
  localparam int RS_LSB   = 8;
  localparam int RD_LSB   = 5;

  localparam int REG_AW   = RS_LSB - RD_LSB;
  localparam int SH_W     = RD_LSB;
  localparam int OP_W     = OP_MSB - (RS_LSB + REG_AW) + 1;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [1:0] IMM_PREFIX = 2'b11;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  // The top two opcode bits select the two-word (immediate) format.
  function automatic logic is_imm_op(input logic [OP_W-1:0] op,
                                     input logic [1:0]      prefix);
    return op[OP_W-1 -: 2] == prefix;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 8x16 register file: one write port, two asynchronous read ports, sync clear.
// Build option DECODE_WB_BYPASS_EN forwards a same-cycle write to the reads.
module register_file
  import isa_pkg::*;
#(
  parameter int DATA_W = isa_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd_a = (wb_en && (wb_addr == ra_a)) ? wb_data : regs_q[ra_a];
  assign rd_b = (wb_en && (wb_addr == ra_b)) ? wb_data : regs_q[ra_b];
`else
  assign rd_a = regs_q[ra_a];
  assign rd_b = regs_q[ra_b];
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: assembles one/two-word instructions, reads operands and drives
// a registered ID/EX bundle. Write-back forwarding via DECODE_WB_BYPASS_EN.
//   state | meaning
//   S_OP  | expecting an opcode word
//   S_IMM | opcode word held, waiting for its 16-bit immediate word
module decode_stage
  import isa_pkg::*;
#(
  parameter int         DATA_W     = isa_pkg::DATA_W,
  parameter int         ADDR_W     = isa_pkg::ADDR_W,
  parameter logic [1:0] IMM_PREFIX = isa_pkg::IMM_PREFIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [OP_W-1:0]   opCode,
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] Rd,
  input  logic [SH_W-1:0]   SHMNT,
  input  logic [DATA_W-1:0] instructionWord,
  input  logic [ADDR_W-1:0] nextInstructionAddress,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [OP_W-1:0]   id_opcode,
  output logic [REG_AW-1:0] id_rd,
  output logic [SH_W-1:0]   id_shmnt,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [DATA_W-1:0] id_imm,
  output logic              id_is_imm,
  output logic [ADDR_W-1:0] id_pc
);

  state_e            state_q, state_d;
  logic              vld_q, vld_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] rd_idx_q, rd_idx_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              is_imm_q, is_imm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [OP_W-1:0]   h_op_q, h_op_d;
  logic [REG_AW-1:0] h_rs_q, h_rs_d;
  logic [REG_AW-1:0] h_rd_q, h_rd_d;
  logic [SH_W-1:0]   h_sh_q, h_sh_d;
  logic [ADDR_W-1:0] h_pc_q, h_pc_d;

  logic [REG_AW-1:0] ra_a, ra_b;
  logic [DATA_W-1:0] rf_a, rf_b;

  // While waiting for the immediate, operands come from the held indices.
  assign ra_a = (state_q == S_IMM) ? h_rs_q : Rs;
  assign ra_b = (state_q == S_IMM) ? h_rd_q : Rd;

  register_file #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .wb_en  (wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .ra_a   (ra_a),
    .ra_b   (ra_b),
    .rd_a   (rf_a),
    .rd_b   (rf_b)
  );

  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    op_d      = op_q;
    rd_idx_d  = rd_idx_q;
    sh_d      = sh_q;
    rs_data_d = rs_data_q;
    rd_data_d = rd_data_q;
    imm_d     = imm_q;
    is_imm_d  = is_imm_q;
    pc_d      = pc_q;
    h_op_d    = h_op_q;
    h_rs_d    = h_rs_q;
    h_rd_d    = h_rd_q;
    h_sh_d    = h_sh_q;
    h_pc_d    = h_pc_q;

    if (flush) begin
      vld_d   = 1'b0;
      state_d = S_OP;
      h_op_d  = '0;
      h_rs_d  = '0;
      h_rd_d  = '0;
      h_sh_d  = '0;
      h_pc_d  = '0;
    end else if (!stall) begin
      vld_d = 1'b0;
      if (if_valid) begin
        if (state_q == S_IMM) begin
          vld_d     = 1'b1;
          op_d      = h_op_q;
          rd_idx_d  = h_rd_q;
          sh_d      = h_sh_q;
          rs_data_d = rf_a;
          rd_data_d = rf_b;
          imm_d     = instructionWord;
          is_imm_d  = 1'b1;
          pc_d      = h_pc_q;
          state_d   = S_OP;
        end else if (is_imm_op(opCode, IMM_PREFIX)) begin
          h_op_d  = opCode;
          h_rs_d  = Rs;
          h_rd_d  = Rd;
          h_sh_d  = SHMNT;
          h_pc_d  = nextInstructionAddress;
          state_d = S_IMM;
        end else begin
          vld_d     = 1'b1;
          op_d      = opCode;
          rd_idx_d  = Rd;
          sh_d      = SHMNT;
          rs_data_d = rf_a;
          rd_data_d = rf_b;
          imm_d     = '0;
          is_imm_d  = 1'b0;
          pc_d      = nextInstructionAddress;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OP;
      vld_q     <= 1'b0;
      op_q      <= '0;
      rd_idx_q  <= '0;
      sh_q      <= '0;
      rs_data_q <= '0;
      rd_data_q <= '0;
      imm_q     <= '0;
      is_imm_q  <= 1'b0;
      pc_q      <= '0;
      h_op_q    <= '0;
      h_rs_q    <= '0;
      h_rd_q    <= '0;
      h_sh_q    <= '0;
      h_pc_q    <= '0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      op_q      <= op_d;
      rd_idx_q  <= rd_idx_d;
      sh_q      <= sh_d;
      rs_data_q <= rs_data_d;
      rd_data_q <= rd_data_d;
      imm_q     <= imm_d;
      is_imm_q  <= is_imm_d;
      pc_q      <= pc_d;
      h_op_q    <= h_op_d;
      h_rs_q    <= h_rs_d;
      h_rd_q    <= h_rd_d;
      h_sh_q    <= h_sh_d;
      h_pc_q    <= h_pc_d;
    end
  end

  assign id_valid   = vld_q;
  assign id_opcode  = op_q;
  assign id_rd      = rd_idx_q;
  assign id_shmnt   = sh_q;
  assign id_rs_data = rs_data_q;
  assign id_rd_data = rd_data_q;
  assign id_imm     = imm_q;
  assign id_is_imm  = is_imm_q;
  assign id_pc      = pc_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the IF/ID interface: takes the fetch stage's per-cycle instruction fields and PC+1, and the raw 16-bit word.
- Assembles one- and two-word instructions; the second word is a 16-bit immediate.
- Reads an 8x16 register file and drives a registered ID/EX bundle to execute.
- Accepts a write-back port from the WB stage.

Parameters:
- DATA_W, 16, register and immediate width.
- ADDR_W, 32, PC width.
- IMM_PREFIX, 2'b11, value of opCode[4:3] that marks a two-word (immediate) instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  IF/ID word present this cycle.
- opCode  in  5  instruction opcode field [15:11].
- Rs  in  3  source register index [10:8].
- Rd  in  3  destination/second-source index [7:5].
- SHMNT  in  5  shift amount [4:0].
- instructionWord  in  16  raw word; used as the immediate in the second-word cycle.
- nextInstructionAddress  in  32  PC+1 of the word.
- stall  in  1  hold ID/EX and internal state.
- flush  in  1  discard the in-flight instruction.
- wb_en  in  1  register-file write enable.
- wb_addr  in  3  write index.
- wb_data  in  16  write data.
- id_valid  out  1  ID/EX bundle valid.
- id_opcode  out  5  decoded opcode.
- id_rd  out  3  destination index.
- id_shmnt  out  5  shift amount.
- id_rs_data  out  16  reg[Rs].
- id_rd_data  out  16  reg[Rd].
- id_imm  out  16  immediate; 0 for one-word instructions.
- id_is_imm  out  1  instruction carried an immediate.
- id_pc  out  32  nextInstructionAddress of the opcode word.

Behaviour:
- Reset: state=S_OP; all outputs 0; all 8 registers cleared to 0; held fields cleared.
- Priority, highest first: rst > flush > stall > normal operation.
- S_OP, if_valid=1, opCode[4:3]!=IMM_PREFIX:
  - Next cycle: id_valid=1, fields from the word, id_imm=0, id_is_imm=0, operands read this cycle.
  - Latency is 1 cycle.
- S_OP, if_valid=1, opCode[4:3]==IMM_PREFIX:
  - Latch opCode, Rs, Rd, SHMNT and nextInstructionAddress.
  - Go to S_IMM; id_valid=0 next cycle.
- S_IMM, if_valid=1:
  - id_imm=instructionWord; held fields driven out; id_is_imm=1; id_valid=1 next cycle.
  - Operands are read in this (second-word) cycle.
  - Return to S_OP.
- S_IMM, if_valid=0: remain in S_IMM; id_valid=0.
- if_valid=0 in S_OP: id_valid=0 next cycle; other outputs hold.
- stall=1: every output, state and held field keeps its value; if_valid is ignored, so fetch must hold its word. Register-file writes still occur.
- flush=1, stall=0 or stall=1: id_valid=0, state=S_OP, held fields discarded; the if_valid word that cycle is dropped.
- Register file:
  - Write on posedge when wb_en=1; all 8 registers are writable.
  - Combinational reads of reg[Rs] and reg[Rd] use current-word indices in S_OP and held indices in S_IMM.
- Reset mid-S_IMM returns to S_OP; the partial instruction is lost.
- PC values pass through unmodified; no arithmetic is performed on them.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when wb_en=1 and wb_addr equals a read index in the sampling cycle, wb_data is forwarded into id_rs_data/id_rd_data.
- Undefined: the read returns the pre-write value; a write becomes visible one cycle later.

Decomposition:
- Shared package isa_pkg holds:
  - Opcode width and field bit positions (OP_MSB=15, RS_LSB=8, RD_LSB=5).
  - IMM_PREFIX.
  - State encoding S_OP/S_IMM.
  - DATA_W/ADDR_W constants.
- One sub-module: register_file (8x16, one write port, two async read ports, sync reset clear); bypass logic lives in it under the macro.

Test Plan:
- One-word instruction: after reset, write reg2=16'h00AA and reg5=16'h0055 via WB. Present opCode=5'b00010, Rs=2, Rd=5, SHMNT=3, nextInstructionAddress=32'h21. Next cycle requires id_valid=1, id_rs_data=16'h00AA, id_rd_data=16'h0055, id_shmnt=3, id_imm=0, id_pc=32'h21.
- Two-word instruction: opCode=5'b11001, Rd=1, then instructionWord=16'hBEEF after 2 if_valid=0 gap cycles. id_valid=0 until the cycle after the second word, then id_imm=16'hBEEF, id_is_imm=1, id_opcode=5'b11001.
- Stall: assert stall for 3 cycles with new if_valid words. The ID/EX bundle stays identical and the new words are not consumed. Release stall and the next word decodes normally.
- Flush in S_IMM: after the immediate-class opcode word, assert flush with the immediate word. Next cycle id_valid=0 and state=S_OP. A following one-word instruction decodes with id_is_imm=0.
- Write-back collision: wb_en=1, wb_addr=3, wb_data=16'h1234 in the same cycle as decoding Rs=3 with prior reg3=0. Result must be id_rs_data=16'h1234 with DECODE_WB_BYPASS_EN defined, or 16'h0000 without it.
- Reset mid-operation: rst during S_IMM gives all outputs 0 the next cycle and all registers reading 0.
